// File: rtl/axi_ic_pkg.sv
// Shared helpers for the AXI interconnect arbiters: round-robin pick, one-hot decode, QoS width.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package axi_ic_pkg;

    // QoS field width per master
    localparam int QOS_W = 4;

    // Helper functions work on vectors sized for the largest supported master count (16)
    localparam int VEC_MAX = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // First set bit of req searching upward from ptr+1, wrapping at n (explicit modulo compare).
    // Callers check that req is non-zero; with no request the result is 0.
    function automatic logic [3:0] rr_pick(input logic [VEC_MAX-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int unsigned        n);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= VEC_MAX; i++) begin
            if (i <= n) begin
                idx = {28'd0, ptr} + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    // Index of the set bit of a one-hot vector (0 for an all-zero vector)
    function automatic logic [3:0] onehot_to_idx(input logic [VEC_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < VEC_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_ic_sel_fifo.sv
// In-order queue of granted master indices that steers the W-channel mux.
// Latency: push visible at dout/empty one cycle later; no write-to-read bypass.
// Backpressure: push ignored when full unless popped in the same cycle; pop ignored when empty.
module axi_ic_sel_fifo
    import axi_ic_pkg::*;
#(
    parameter int Q_DEPTH = 4,
    parameter int SELW    = 2,
    parameter int LVLW    = $clog2(Q_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [SELW-1:0] din,
    output logic [SELW-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic [LVLW-1:0] level
);

    localparam int PTRW = $clog2(Q_DEPTH);

    logic [SELW-1:0] mem_q [Q_DEPTH];
    logic [SELW-1:0] mem_d [Q_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q, level_d;
    logic            do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVLW'(Q_DEPTH));
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: write at tail, advance head, track occupancy (push+pop leaves level unchanged)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // State registers; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Per-slave-port AW round-robin arbiter with in-order W steering queue (QoS priority under AXI_ARB_QOS_EN).
// Latency: request to grant 1 cycle; AW handshake to w_sel_vld 1 cycle; back-to-back grants without bubbles.
// Backpressure: grant held until AW handshake; no new grant while the steering queue plus held grant is full.
module axi_wr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int MST_N   = 4,
    parameter int SELW    = $clog2(MST_N),
    parameter int Q_DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [MST_N-1:0]         aw_req,
`ifdef AXI_ARB_QOS_EN
    input  logic [MST_N*4-1:0]       aw_qos,
`endif
    output logic [MST_N-1:0]         aw_gnt,
    input  logic                     aw_ready,
    output logic [SELW-1:0]          w_sel,
    output logic                     w_sel_vld,
    input  logic                     w_last_hs,
    output logic                     err,
    output logic [$clog2(Q_DEPTH):0] q_level
);

    localparam int LVLW = $clog2(Q_DEPTH) + 1;

    arb_state_e         state_q, state_d;
    logic [MST_N-1:0]   aw_gnt_q, aw_gnt_d;
    logic [SELW-1:0]    rr_ptr_q, rr_ptr_d;
    logic               err_q, err_d;

    logic [VEC_MAX-1:0] gnt_ext, req_ext;
    logic [3:0]         gnt_idx, ptr_ext, pick_idx;
    logic [MST_N-1:0]   base_req, cand_req, new_gnt;
    logic               aw_hs, withdrawn, room;
    logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [SELW-1:0]    fifo_dout;
    logic [LVLW-1:0]    fifo_level;
    logic               unused_bits;

    assign aw_hs     = (state_q == ARB_HOLD) && (|(aw_gnt_q & aw_req)) && aw_ready;
    assign withdrawn = (state_q == ARB_HOLD) && !(|(aw_gnt_q & aw_req));
    // The master completing its handshake this cycle cannot already hold a new AW, so it sits out
    assign base_req  = aw_req & ~(aw_hs ? aw_gnt_q : '0);
    assign fifo_pop  = w_last_hs && !fifo_empty;
    assign fifo_push = aw_hs && (!fifo_full || fifo_pop);

    // Candidate filter: with QoS only the highest-QoS requesters compete, ties go to round robin
    always_comb begin
        cand_req = base_req;
`ifdef AXI_ARB_QOS_EN
        begin
            logic [QOS_W-1:0] qos_max;
            qos_max = '0;
            for (int i = 0; i < MST_N; i++) begin
                if (base_req[i] && (aw_qos[i*QOS_W +: QOS_W] > qos_max)) begin
                    qos_max = aw_qos[i*QOS_W +: QOS_W];
                end
            end
            for (int i = 0; i < MST_N; i++) begin
                cand_req[i] = base_req[i] && (aw_qos[i*QOS_W +: QOS_W] == qos_max);
            end
        end
`endif
    end

    // Round-robin pick, searching from the just-handshaken winner so re-arbitration has no bubble
    always_comb begin
        gnt_ext                 = '0;
        gnt_ext[MST_N-1:0]      = aw_gnt_q;
        gnt_idx                 = onehot_to_idx(gnt_ext);
        req_ext                 = '0;
        req_ext[MST_N-1:0]      = cand_req;
        ptr_ext                 = '0;
        ptr_ext[SELW-1:0]       = aw_hs ? gnt_idx[SELW-1:0] : rr_ptr_q;
        pick_idx                = rr_pick(req_ext, ptr_ext, MST_N);
        new_gnt                 = '0;
        new_gnt[pick_idx[SELW-1:0]] = 1'b1;
        // A held grant counts as a queue slot already spoken for
        room = (int'(fifo_level) + ((state_q == ARB_HOLD) ? 1 : 0)) < Q_DEPTH;
    end

    // FSM next-state, grant register and round-robin pointer update; err is sticky
    always_comb begin
        state_d  = state_q;
        aw_gnt_d = aw_gnt_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q | (w_last_hs & fifo_empty);
        case (state_q)
            ARB_IDLE: begin
                if ((|cand_req) && room) begin
                    state_d  = ARB_HOLD;
                    aw_gnt_d = new_gnt;
                end
            end
            ARB_HOLD: begin
                if (aw_hs) begin
                    rr_ptr_d = gnt_idx[SELW-1:0];
                    if ((|cand_req) && room) begin
                        aw_gnt_d = new_gnt;
                    end else begin
                        state_d  = ARB_IDLE;
                        aw_gnt_d = '0;
                    end
                end else if (withdrawn) begin
                    state_d  = ARB_IDLE;
                    aw_gnt_d = '0;
                end
            end
        endcase
    end

    // State registers; pointer resets to the last master so master 0 wins first
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ARB_IDLE;
            aw_gnt_q <= '0;
            rr_ptr_q <= SELW'(MST_N - 1);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_gnt_q <= aw_gnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    axi_ic_sel_fifo #(
        .Q_DEPTH (Q_DEPTH),
        .SELW    (SELW),
        .LVLW    (LVLW)
    ) u_sel_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (gnt_idx[SELW-1:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Helper vectors are sized for 16 masters; fold the spare bits so they are not left dangling
    assign unused_bits = ^{gnt_ext, req_ext, gnt_idx, ptr_ext, pick_idx};

    assign aw_gnt    = aw_gnt_q;
    assign w_sel     = fifo_dout;
    assign w_sel_vld = !fifo_empty;
    assign q_level   = fifo_level;
    assign err       = err_q;

endmodule
